// File: rtl/mc_axi_if_pkg.sv
// Shared types and constants for the MC AXI slave: burst/response encodings,
// the write-path state enum and the per-beat MC write command layout.
package mc_axi_if_pkg;

    localparam int MC_ADDR_W = 64;
    localparam int MC_DATA_W = 512;
    localparam int MC_ID_W   = 8;

    localparam int          MC_LINE_BYTES = 64;
    localparam logic [2:0]  MC_LINE_SIZE  = 3'd6;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        RESP
    } wr_state_t;

    typedef struct packed {
        logic [MC_ADDR_W-1:0]   addr;
        logic [MC_DATA_W-1:0]   data;
        logic [MC_DATA_W/8-1:0] be;
        logic [MC_ID_W-1:0]     id;
        logic                   last;
    } mc_wr_cmd_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/mc_axi_addr_step.sv
// Next-beat line address for FIXED/INCR/WRAP bursts of 64-byte beats.
module mc_axi_addr_step
    import mc_axi_if_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] cur_addr,
    input  logic [1:0]        burst,
    input  logic [7:0]        len,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        incr_addr = cur_addr + ADDR_W'(MC_LINE_BYTES);
        // Wrap window spans (len+1) lines; only the low bits inside it move.
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << MC_LINE_SIZE) - ADDR_W'(1);
        next_addr = cur_addr;
        case (burst)
            BURST_FIXED: next_addr = cur_addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = cur_addr;
        endcase
    end

endmodule

// File: rtl/mc_axi_wr_beat_gen.sv
// AXI4 write-burst front end: accepts one AW/W burst, forwards each beat as a
// 64-byte MC write command with no data buffering, then returns B.
module mc_axi_wr_beat_gen
    import mc_axi_if_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 512,
    parameter int ID_W           = 8,
    parameter int SKIP_ZERO_STRB = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                mc_wr_valid,
    input  logic                mc_wr_ready,
    output logic [ADDR_W-1:0]   mc_wr_addr,
    output logic [DATA_W-1:0]   mc_wr_data,
    output logic [DATA_W/8-1:0] mc_wr_be,
    output logic [ID_W-1:0]     mc_wr_id,
    output logic                mc_wr_last,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp
);

    wr_state_t          state_reg, state_next;
    logic [ID_W-1:0]    id_reg;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [7:0]         len_reg;
    logic [1:0]         burst_reg;
    logic [7:0]         beat_cnt_reg;
    logic               err_reg;

    logic aw_err;
    logic fwd;
    logic aw_hs;
    logic w_hs;

    mc_axi_addr_step #(
        .ADDR_W (ADDR_W)
    ) u_addr_step (
        .cur_addr  (addr_reg),
        .burst     (burst_reg),
        .len       (len_reg),
        .next_addr (addr_next)
    );

    always_comb begin
        aw_err = (awsize != MC_LINE_SIZE) || (awburst == BURST_RSVD) || (awaddr[5:0] != 6'd0) ||
                 ((awburst == BURST_WRAP) && !wrap_len_ok(awlen));
        fwd = !err_reg && (beat_cnt_reg <= len_reg) && !((SKIP_ZERO_STRB != 0) && (wstrb == '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        awready     = 1'b0;
        wready      = 1'b0;
        mc_wr_valid = 1'b0;
        mc_wr_last  = 1'b0;
        bvalid      = 1'b0;
        bid         = '0;
        bresp       = RESP_OKAY;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        case (state_reg)
            IDLE: begin
                awready = 1'b1;
                aw_hs   = awvalid;
                if (awvalid) state_next = BURST;
            end
            BURST: begin
                // Non-forwarded beats drain regardless of MC backpressure.
                wready      = fwd ? mc_wr_ready : 1'b1;
                mc_wr_valid = wvalid && fwd;
                mc_wr_last  = wlast && fwd;
                w_hs        = wvalid && wready;
                if (w_hs && wlast) state_next = RESP;
            end
            RESP: begin
                bvalid = 1'b1;
                bid    = id_reg;
                bresp  = err_reg ? RESP_SLVERR : RESP_OKAY;
                if (bready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mc_wr_addr = addr_reg;
    assign mc_wr_data = wdata;
    assign mc_wr_be   = wstrb;
    assign mc_wr_id   = id_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_reg       <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            burst_reg    <= '0;
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else if (aw_hs) begin
            id_reg       <= awid;
            addr_reg     <= awaddr;
            len_reg      <= awlen;
            burst_reg    <= awburst;
            beat_cnt_reg <= '0;
            err_reg      <= aw_err;
        end else if (w_hs) begin
            beat_cnt_reg <= (beat_cnt_reg == 8'hFF) ? 8'hFF : beat_cnt_reg + 8'd1;
            addr_reg     <= addr_next;
            // Early or late wlast both end the burst with SLVERR.
            if (wlast && (beat_cnt_reg != len_reg)) err_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_axi_wr_beat_gen.sv
// Directed test of the AXI write beat generator: INCR/WRAP streaming, error
// bursts, early wlast, MC/B backpressure, zero-strobe skipping, mid-burst reset.
module tb_mc_axi_wr_beat_gen;
    import mc_axi_if_pkg::*;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int ID_W   = 8;
    localparam int BE_W   = DATA_W / 8;
    localparam logic [BE_W-1:0] ALL_BE = '1;

    logic              clk;
    logic              reset_n;
    logic              awvalid;
    logic              awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   wstrb;
    logic              wlast;
    logic              mc_wr_valid;
    logic              mc_wr_ready;
    logic [ADDR_W-1:0] mc_wr_addr;
    logic [DATA_W-1:0] mc_wr_data;
    logic [BE_W-1:0]   mc_wr_be;
    logic [ID_W-1:0]   mc_wr_id;
    logic              mc_wr_last;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    int n_cmp = 0;
    int n_bad = 0;

    mc_axi_wr_beat_gen #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .ID_W           (ID_W),
        .SKIP_ZERO_STRB (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .awvalid     (awvalid),
        .awready     (awready),
        .awid        (awid),
        .awaddr      (awaddr),
        .awlen       (awlen),
        .awsize      (awsize),
        .awburst     (awburst),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wlast       (wlast),
        .mc_wr_valid (mc_wr_valid),
        .mc_wr_ready (mc_wr_ready),
        .mc_wr_addr  (mc_wr_addr),
        .mc_wr_data  (mc_wr_data),
        .mc_wr_be    (mc_wr_be),
        .mc_wr_id    (mc_wr_id),
        .mc_wr_last  (mc_wr_last),
        .bvalid      (bvalid),
        .bready      (bready),
        .bid         (bid),
        .bresp       (bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        awvalid = 1'b1;
        awid    = id;
        awaddr  = addr;
        awlen   = len;
        awsize  = size;
        awburst = burst;
        #1;
        chk("aw_ready", awready, 1'b1);
        $display("AW   id=%02h addr=%0h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [7:0] id, input logic [15:0] pat,
                        input logic [BE_W-1:0] strb, input logic last, input logic rdy,
                        input logic exp_valid, input logic [63:0] exp_addr, input logic exp_wready);
        wvalid      = 1'b1;
        wdata       = {32{pat}};
        wstrb       = strb;
        wlast       = last;
        mc_wr_ready = rdy;
        #1;
        chk({tag, "_valid"}, mc_wr_valid, exp_valid);
        chk({tag, "_wready"}, wready, exp_wready);
        if (exp_valid) begin
            chk({tag, "_addr"}, mc_wr_addr, exp_addr);
            chk({tag, "_data"}, mc_wr_data, {32{pat}});
            chk({tag, "_be"}, mc_wr_be, strb);
            chk({tag, "_id"}, mc_wr_id, id);
            chk({tag, "_last"}, mc_wr_last, last);
        end
        $display("W    %s pat=%04h last=%0d mc_valid=%0d addr=%0h", tag, pat, last, mc_wr_valid, mc_wr_addr);
        tick();
        wvalid      = 1'b0;
        wlast       = 1'b0;
        mc_wr_ready = 1'b1;
    endtask

    task automatic resp(input string tag, input logic [7:0] id, input logic [1:0] rsp);
        bready = 1'b1;
        #1;
        chk({tag, "_bvalid"}, bvalid, 1'b1);
        chk({tag, "_bid"}, bid, id);
        chk({tag, "_bresp"}, bresp, rsp);
        chk({tag, "_awready_resp"}, awready, 1'b0);
        $display("B    %s bid=%02h bresp=%0d", tag, bid, bresp);
        tick();
        bready = 1'b0;
        #1;
        chk({tag, "_bvalid_done"}, bvalid, 1'b0);
        chk({tag, "_awready_idle"}, awready, 1'b1);
    endtask

    initial begin
        reset_n     = 1'b0;
        awvalid     = 1'b0;
        awid        = '0;
        awaddr      = '0;
        awlen       = '0;
        awsize      = '0;
        awburst     = '0;
        wvalid      = 1'b0;
        wdata       = '0;
        wstrb       = '0;
        wlast       = 1'b0;
        mc_wr_ready = 1'b1;
        bready      = 1'b0;

        tick();
        tick();
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b0);
        chk("rst_mc_valid", mc_wr_valid, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bid", bid, 8'h00);
        chk("rst_bresp", bresp, 2'b00);
        reset_n = 1'b1;
        tick();

        // INCR, 4 beats from 0x1000
        aw(8'h5A, 64'h1000, 8'd3, 3'd6, BURST_INCR);
        beat("incr0", 8'h5A, 16'hA000, ALL_BE, 1'b0, 1'b1, 1'b1, 64'h1000, 1'b1);
        beat("incr1", 8'h5A, 16'hA001, ALL_BE, 1'b0, 1'b1, 1'b1, 64'h1040, 1'b1);
        beat("incr2", 8'h5A, 16'hA002, {32'h0000_FFFF, 32'hF0F0_0001}, 1'b0, 1'b1, 1'b1, 64'h1080, 1'b1);
        beat("incr3", 8'h5A, 16'hA003, ALL_BE, 1'b1, 1'b1, 1'b1, 64'h10C0, 1'b1);
        resp("incr_b", 8'h5A, RESP_OKAY);

        // WRAP, 4 beats starting at the top line of a 256-byte window
        aw(8'h2B, 64'h10C0, 8'd3, 3'd6, BURST_WRAP);
        beat("wrap0", 8'h2B, 16'hB000, ALL_BE, 1'b0, 1'b1, 1'b1, 64'h10C0, 1'b1);
        beat("wrap1", 8'h2B, 16'hB001, ALL_BE, 1'b0, 1'b1, 1'b1, 64'h1000, 1'b1);
        beat("wrap2", 8'h2B, 16'hB002, ALL_BE, 1'b0, 1'b1, 1'b1, 64'h1040, 1'b1);
        beat("wrap3", 8'h2B, 16'hB003, ALL_BE, 1'b1, 1'b1, 1'b1, 64'h1080, 1'b1);
        resp("wrap_b", 8'h2B, RESP_OKAY);

        // Wrong awsize: beats drain even while MC is not ready
        aw(8'h22, 64'h2000, 8'd1, 3'd5, BURST_INCR);
        beat("bad0", 8'h22, 16'hC000, ALL_BE, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        beat("bad1", 8'h22, 16'hC001, ALL_BE, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        resp("bad_b", 8'h22, RESP_SLVERR);

        // Early wlast on beat 2 of 4
        aw(8'h33, 64'h3000, 8'd3, 3'd6, BURST_INCR);
        beat("early0", 8'h33, 16'hD000, ALL_BE, 1'b0, 1'b1, 1'b1, 64'h3000, 1'b1);
        beat("early1", 8'h33, 16'hD001, ALL_BE, 1'b1, 1'b1, 1'b1, 64'h3040, 1'b1);
        awvalid = 1'b1;
        awid    = 8'h44;
        awaddr  = 64'h5000;
        awlen   = 8'd1;
        awsize  = 3'd6;
        awburst = BURST_INCR;
        #1;
        chk("early_bvalid", bvalid, 1'b1);
        chk("early_bresp", bresp, RESP_SLVERR);
        chk("early_aw_blocked0", awready, 1'b0);
        tick();
        chk("early_aw_blocked1", awready, 1'b0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        #1;
        chk("early_aw_after_b", awready, 1'b1);
        $display("AW   id=44 accepted after B handshake");
        tick();
        awvalid = 1'b0;

        // MC backpressure toggling, then B held off for 5 cycles
        wvalid      = 1'b1;
        wdata       = {32{16'hE000}};
        wstrb       = ALL_BE;
        wlast       = 1'b0;
        mc_wr_ready = 1'b0;
        #1;
        chk("stall0_valid", mc_wr_valid, 1'b1);
        chk("stall0_wready", wready, 1'b0);
        chk("stall0_addr", mc_wr_addr, 64'h5000);
        tick();
        beat("stall0", 8'h44, 16'hE000, ALL_BE, 1'b0, 1'b1, 1'b1, 64'h5000, 1'b1);
        wvalid      = 1'b1;
        wdata       = {32{16'hE001}};
        wlast       = 1'b1;
        mc_wr_ready = 1'b0;
        #1;
        chk("stall1_valid", mc_wr_valid, 1'b1);
        chk("stall1_wready", wready, 1'b0);
        chk("stall1_last", mc_wr_last, 1'b1);
        chk("stall1_addr", mc_wr_addr, 64'h5040);
        tick();
        beat("stall1", 8'h44, 16'hE001, ALL_BE, 1'b1, 1'b1, 1'b1, 64'h5040, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bhold_bvalid", bvalid, 1'b1);
            chk("bhold_awready", awready, 1'b0);
            chk("bhold_bid", bid, 8'h44);
            tick();
        end
        resp("stall_b", 8'h44, RESP_OKAY);

        // Zero-strobe middle beat is skipped
        aw(8'h66, 64'h0, 8'd2, 3'd6, BURST_INCR);
        beat("skip0", 8'h66, 16'hF000, ALL_BE, 1'b0, 1'b1, 1'b1, 64'h0, 1'b1);
        beat("skip1", 8'h66, 16'hF001, '0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        beat("skip2", 8'h66, 16'hF002, ALL_BE, 1'b1, 1'b1, 1'b1, 64'h80, 1'b1);
        resp("skip_b", 8'h66, RESP_OKAY);

        // Reset in the middle of a burst
        aw(8'h77, 64'h6000, 8'd3, 3'd6, BURST_INCR);
        beat("rst0", 8'h77, 16'h7000, ALL_BE, 1'b0, 1'b1, 1'b1, 64'h6000, 1'b1);
        wvalid      = 1'b1;
        wdata       = {32{16'h7001}};
        mc_wr_ready = 1'b0;
        #1;
        chk("rst_mid_valid_pre", mc_wr_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", mc_wr_valid, 1'b0);
        chk("rst_mid_wready", wready, 1'b0);
        chk("rst_mid_awready", awready, 1'b1);
        chk("rst_mid_bvalid", bvalid, 1'b0);
        chk("rst_mid_bid", bid, 8'h00);
        $display("RST  asserted mid-burst");
        wvalid      = 1'b0;
        mc_wr_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        aw(8'h11, 64'h7000, 8'd0, 3'd6, BURST_INCR);
        beat("post_rst", 8'h11, 16'h1100, ALL_BE, 1'b1, 1'b1, 1'b1, 64'h7000, 1'b1);
        resp("post_rst_b", 8'h11, RESP_OKAY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_axi_wr_beat_gen.md
Name: mc_axi_wr_beat_gen

Overview:
- Write-path front end of the memory controller AXI slave. Accepts one AXI4 write burst at a time on the AW and W channels and splits it into per-beat 64-byte MC write commands.
- Returns the B response once the burst completes.
- Sits directly upstream of the MC write-command queue. Consumes the aw/w fields that the mc_axi_if_pkg write structs carry.

Parameters:
- ADDR_W, 64, AXI/MC address width.
- DATA_W, 512, beat data width; the line size is DATA_W/8 = 64 bytes.
- ID_W, 8, AXI ID width.
- SKIP_ZERO_STRB, 1, when 1, beats with wstrb==0 are consumed without issuing an MC write.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- awvalid  in  1  AW valid.
- awready  out  1  AW ready.
- awid  in  ID_W  burst ID.
- awaddr  in  ADDR_W  start address.
- awlen  in  8  beats minus 1.
- awsize  in  3  log2 of bytes per beat.
- awburst  in  2  burst type.
- wvalid  in  1  W valid.
- wready  out  1  W ready.
- wdata  in  DATA_W  beat data.
- wstrb  in  DATA_W/8  byte strobes.
- wlast  in  1  last beat.
- mc_wr_valid  out  1  MC command valid.
- mc_wr_ready  in  1  MC command ready.
- mc_wr_addr  out  ADDR_W  line address of the beat.
- mc_wr_data  out  DATA_W  beat data.
- mc_wr_be  out  DATA_W/8  byte enables.
- mc_wr_id  out  ID_W  burst ID.
- mc_wr_last  out  1  final forwarded beat of the burst.
- bvalid  out  1  B valid.
- bready  in  1  B ready.
- bid  out  ID_W  response ID.
- bresp  out  2  response code: 00 OKAY, 10 SLVERR.

Behaviour:
- Reset values: state=IDLE; awready=1; wready=0; mc_wr_valid=0; bvalid=0; bid=0; bresp=0. Internal registers are cleared.
- Reset mid-burst abandons the burst with no B response. Upstream is reset by the same reset_n.

State IDLE:
- awready=1.
- On the AW handshake, latch id, addr, len and burst, clear beat_cnt, then go to BURST.
- err is latched on the same handshake. It is set if any of the following holds:
  - awsize != 3'd6
  - awburst == 2'b11
  - awaddr[5:0] != 0
  - WRAP burst with awlen not in {1,3,7,15}

State BURST (zero-latency pass-through, no data register):
- A beat is "fwd" when all of these hold: !err, beat_cnt<=len, and !(SKIP_ZERO_STRB && wstrb==0).
- Handshake signals:
  - mc_wr_valid = wvalid && fwd.
  - wready = fwd ? mc_wr_ready : 1. Non-forwarded beats drain at one per cycle.
- mc_wr_addr = cur_addr, mc_wr_data = wdata, mc_wr_be = wstrb, mc_wr_id = latched id.
- mc_wr_last = wlast, qualified by fwd.
- On each W handshake:
  - beat_cnt saturates at 255.
  - cur_addr advances:
    - FIXED: unchanged.
    - INCR: +64, with ADDR_W wrap-around.
    - WRAP: mask=((len+1)<<6)-1; cur_addr = (cur_addr & ~mask) | ((cur_addr+64) & mask).
- The burst always ends on the beat with wlast=1, then goes to RESP.
- wlast with beat_cnt!=len sets err (early or late last). Beats beyond len+1 are drained, not forwarded.
- A burst whose beats are all skipped produces no mc_wr_last. That is legal for the MC.

State RESP:
- bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00.
- Held until bready, then go to IDLE.
- awready stays 0 until IDLE. The next AW is accepted no earlier than the cycle after the B handshake.

General:
- AXI stability is required of the source. Once asserted, mc_wr_valid stays high with stable payload until mc_wr_ready, because W is held.
- 4 KB crossing is not checked.
- Throughput: 1 beat/cycle with mc_wr_ready=1. Burst overhead is 2 cycles (AW cycle plus RESP cycle with bready=1).

Decomposition:
- Add to mc_axi_if_pkg:
  - the state enum (IDLE, BURST, RESP)
  - MC_LINE_BYTES=64 and MC_LINE_SIZE=3'd6
  - reuse of the BURST_* and RESP_* constants
  - an mc_wr_cmd_t struct (addr, data, be, id, last)
- One sub-module: mc_axi_addr_step. It is combinational: cur_addr, burst and len in, next_addr out, and is unit-testable.

Test Plan:
- INCR, awaddr=0x1000, len=3, size=6, mc_wr_ready=1 → 4 MC writes at 0x1000/1040/1080/10C0, last on the 4th, then bvalid with OKAY and bid=awid.
- WRAP, awaddr=0x10C0, len=3 → addresses 0x10C0, 0x1000, 0x1040, 0x1080; bresp=00.
- awsize=5, len=1 → 2 W beats drained with wready=1, no mc_wr_valid, bresp=10.
- INCR, len=3, wlast on beat 2 → 2 MC writes, burst ends, bresp=10. Next AW is accepted only after the B handshake.
- mc_wr_ready toggling 1/0 each cycle, plus bready held low 5 cycles → payload stable while stalled, bvalid held, awready=0 throughout.
- SKIP_ZERO_STRB=1, len=2, middle beat wstrb=0 → 2 MC writes at 0x0 and 0x80. reset_n asserted mid-burst → all outputs reach reset values immediately.
